// File: rtl/zap_reset_sequencer_pkg.sv
// Shared definitions for the ZAP reset sequencer: FSM encoding and cause bit layout.
package zap_reset_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ASSERT  = 2'd1,
      ST_RELEASE = 2'd2
   } state_t;

   // Cause register bit recording the block reset input; request k lives at bit k+1.
   localparam int CAUSE_RESET_N_BIT = 0;

endpackage

// File: rtl/zap_reset_sequencer_req_sync.sv
// One-bit flop-chain synchroniser for an asynchronous reset request.
module zap_reset_req_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic i_clk,
   input  logic i_reset_n,
   input  logic i_req,
   output logic o_req
);

   logic [SYNC_STAGES-1:0] chain;

   // Shift the raw request through the chain; block reset empties it.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) chain <= '0;
      else            chain <= {chain[SYNC_STAGES-2:0], i_req};
   end

   assign o_req = chain[SYNC_STAGES-1];

endmodule

// File: rtl/zap_reset_sequencer.sv
// Reset sequencer: merges synced requests, stretches assertion, then releases
// domains in ascending order with a fixed stagger, and keeps a sticky cause record.
module zap_reset_sequencer
   import zap_reset_sequencer_pkg::*;
#(
   parameter int NUM_REQ     = 2,
   parameter int NUM_DOMAINS = 3,
   parameter int SYNC_STAGES = 2,
   parameter int MIN_ASSERT  = 16,
   parameter int STAGGER     = 4
) (
   input  logic                   i_clk,
   input  logic                   i_reset_n,
   input  logic [NUM_REQ-1:0]     i_rst_req,
   input  logic                   i_cause_clr,
   output logic [NUM_DOMAINS-1:0] o_reset,
   output logic                   o_busy,
   output logic [NUM_REQ:0]       o_reset_cause
);

   localparam int CW     = $clog2(MIN_ASSERT + 1);
   localparam int SW     = $clog2(STAGGER + 1);
   localparam int IW     = $clog2(NUM_DOMAINS + 1);
   localparam int CAUSEW = NUM_REQ + 1;

   localparam logic [CW-1:0] CNT_LAST  = CW'(MIN_ASSERT - 1);
   localparam logic [SW-1:0] SCNT_LAST = SW'(STAGGER - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DOMAINS - 1);

   logic [NUM_REQ-1:0] req_sync;
   logic               req_any;

   state_t                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [SW-1:0]          scnt_q, scnt_d;
   logic [IW-1:0]          idx_q, idx_d;
   logic [NUM_DOMAINS-1:0] rst_q, rst_d;
   logic                   busy_q, busy_d;
   logic [CAUSEW-1:0]      cause_q, cause_d;

   genvar g;
   generate
      for (g = 0; g < NUM_REQ; g++) begin : g_sync
         zap_reset_req_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .i_clk     (i_clk),
            .i_reset_n (i_reset_n),
            .i_req     (i_rst_req[g]),
            .o_req     (req_sync[g])
         );
      end
   endgenerate

   assign req_any = |req_sync;

   // Next-state: stretch in ASSERT, staggered ascending release, requests always win.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      scnt_d  = scnt_q;
      idx_d   = idx_q;
      rst_d   = rst_q;
      busy_d  = busy_q;
      case (state_q)
         ST_IDLE: begin
            rst_d  = '0;
            busy_d = 1'b0;
            if (req_any) begin
               state_d = ST_ASSERT;
               rst_d   = '1;
               busy_d  = 1'b1;
               cnt_d   = '0;
            end
         end
         ST_ASSERT: begin
            if (req_any) begin
               cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
               cnt_d    = '0;
               scnt_d   = '0;
               idx_d    = IW'(1);
               rst_d[0] = 1'b0;
               if (NUM_DOMAINS == 1) begin
                  state_d = ST_IDLE;
                  busy_d  = 1'b0;
               end else begin
                  state_d = ST_RELEASE;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_RELEASE: begin
            if (req_any) begin
               state_d = ST_ASSERT;
               rst_d   = '1;
               busy_d  = 1'b1;
               cnt_d   = '0;
            end else if (scnt_q == SCNT_LAST) begin
               scnt_d = '0;
               idx_d  = idx_q + IW'(1);
               for (int d = 0; d < NUM_DOMAINS; d++) begin
                  if (idx_q == IW'(d)) rst_d[d] = 1'b0;
               end
               if (idx_q == IDX_LAST) begin
                  state_d = ST_IDLE;
                  busy_d  = 1'b0;
               end
            end else begin
               scnt_d = scnt_q + SW'(1);
            end
         end
         default: begin
            state_d = ST_ASSERT;
            rst_d   = '1;
            busy_d  = 1'b1;
            cnt_d   = '0;
         end
      endcase
   end

   // Sticky cause: a clear and a same-cycle set resolve in favour of the set.
   always_comb begin
      cause_d = (i_cause_clr ? '0 : cause_q) | {req_sync, 1'b0};
   end

   // State and output registers; block reset forces full assertion from any state.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state_q <= ST_ASSERT;
         cnt_q   <= '0;
         scnt_q  <= '0;
         idx_q   <= '0;
         rst_q   <= '1;
         busy_q  <= 1'b1;
         cause_q <= CAUSEW'(1) << CAUSE_RESET_N_BIT;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         scnt_q  <= scnt_d;
         idx_q   <= idx_d;
         rst_q   <= rst_d;
         busy_q  <= busy_d;
         cause_q <= cause_d;
      end
   end

   assign o_reset       = rst_q;
   assign o_busy        = busy_q;
   assign o_reset_cause = cause_q;

endmodule

// File: tb/tb_zap_reset_sequencer.sv
// Directed bench for zap_reset_sequencer: default instance plus a minimal-parameter instance.
module tb_zap_reset_sequencer;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [1:0] rst_req;
   logic       cause_clr;

   logic [2:0] a_reset;
   logic       a_busy;
   logic [2:0] a_cause;
   logic [0:0] b_reset;
   logic       b_busy;
   logic [2:0] b_cause;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   zap_reset_sequencer u_a (
      .i_clk         (clk),
      .i_reset_n     (reset_n),
      .i_rst_req     (rst_req),
      .i_cause_clr   (cause_clr),
      .o_reset       (a_reset),
      .o_busy        (a_busy),
      .o_reset_cause (a_cause)
   );

   zap_reset_sequencer #(.NUM_DOMAINS(1), .STAGGER(1), .MIN_ASSERT(1)) u_b (
      .i_clk         (clk),
      .i_reset_n     (reset_n),
      .i_rst_req     (rst_req),
      .i_cause_clr   (cause_clr),
      .o_reset       (b_reset),
      .o_busy        (b_busy),
      .o_reset_cause (b_cause)
   );

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset_n   = 1'b0;
      rst_req   = 2'b00;
      cause_clr = 1'b0;

      // 1: power-on reset then full staggered release
      tick(5);
      chk("t1_rst_reset", {5'd0, a_reset}, 8'h07);
      chk("t1_rst_busy",  {7'd0, a_busy},  8'h01);
      chk("t1_rst_cause", {5'd0, a_cause}, 8'h01);
      reset_n = 1'b1;
      tick(1);
      chk("t1_b_idle",    {7'd0, b_reset}, 8'h00);
      tick(14);
      chk("t1_e15",       {5'd0, a_reset}, 8'h07);
      tick(1);
      chk("t1_e16",       {5'd0, a_reset}, 8'h06);
      tick(3);
      chk("t1_e19",       {5'd0, a_reset}, 8'h06);
      tick(1);
      chk("t1_e20",       {5'd0, a_reset}, 8'h04);
      tick(3);
      chk("t1_e23_busy",  {7'd0, a_busy},  8'h01);
      tick(1);
      chk("t1_e24",       {5'd0, a_reset}, 8'h00);
      chk("t1_e24_busy",  {7'd0, a_busy},  8'h00);
      chk("t1_cause",     {5'd0, a_cause}, 8'h01);

      // 2: request 1 held three cycles from IDLE
      rst_req = 2'b10;
      tick(1);
      chk("t2_n",         {5'd0, a_reset}, 8'h00);
      tick(1);
      chk("t2_n1",        {5'd0, a_reset}, 8'h00);
      tick(1);
      chk("t2_n2",        {5'd0, a_reset}, 8'h07);
      chk("t2_cause",     {5'd0, a_cause}, 8'h05);
      chk("t2_b_n2",      {7'd0, b_reset}, 8'h01);
      rst_req = 2'b00;
      tick(2);
      chk("t6_b_n4",      {7'd0, b_reset}, 8'h01);
      tick(1);
      chk("t6_b_n5",      {7'd0, b_reset}, 8'h00);
      chk("t6_b_busy",    {7'd0, b_busy},  8'h00);
      tick(14);
      chk("t2_n19",       {5'd0, a_reset}, 8'h07);
      tick(1);
      chk("t2_n20",       {5'd0, a_reset}, 8'h06);
      tick(8);
      chk("t2_n28",       {5'd0, a_reset}, 8'h00);

      // 3: request 0 arrives mid-release and restarts the whole sequence
      reset_n = 1'b0;
      tick(2);
      chk("t3_rst_cause", {5'd0, a_cause}, 8'h01);
      reset_n = 1'b1;
      tick(16);
      chk("t3_e16",       {5'd0, a_reset}, 8'h06);
      rst_req = 2'b01;
      tick(2);
      chk("t3_e18",       {5'd0, a_reset}, 8'h06);
      rst_req = 2'b00;
      tick(1);
      chk("t3_e19",       {5'd0, a_reset}, 8'h07);
      chk("t3_e19_cause", {5'd0, a_cause}, 8'h03);
      tick(16);
      chk("t3_e35",       {5'd0, a_reset}, 8'h07);
      tick(1);
      chk("t3_e36",       {5'd0, a_reset}, 8'h06);
      tick(4);
      chk("t3_e40",       {5'd0, a_reset}, 8'h04);
      tick(4);
      chk("t3_e44",       {5'd0, a_reset}, 8'h00);
      chk("t3_cause",     {5'd0, a_cause}, 8'h03);

      // 4: request toggled every 8 cycles keeps the stretch counter reloading
      for (int i = 0; i < 8; i++) begin
         rst_req = (i % 2 == 0) ? 2'b01 : 2'b00;
         tick(8);
         chk($sformatf("t4_blk%0d", i), {5'd0, a_reset}, 8'h07);
      end
      tick(9);
      chk("t4_hold",      {5'd0, a_reset}, 8'h07);
      tick(1);
      chk("t4_release",   {5'd0, a_reset}, 8'h06);
      tick(8);
      chk("t4_done",      {5'd0, a_reset}, 8'h00);

      // 5: cause clear alone, then clear racing a synced set
      cause_clr = 1'b1;
      tick(1);
      cause_clr = 1'b0;
      chk("t5_clr",       {5'd0, a_cause}, 8'h00);
      rst_req = 2'b10;
      tick(2);
      cause_clr = 1'b1;
      tick(1);
      cause_clr = 1'b0;
      rst_req   = 2'b00;
      chk("t5_clr_set",   {5'd0, a_cause}, 8'h04);

      // 6: block reset mid-release
      tick(18);
      chk("t6_p20",       {5'd0, a_reset}, 8'h06);
      tick(2);
      chk("t6_p22",       {5'd0, a_reset}, 8'h06);
      reset_n = 1'b0;
      tick(1);
      chk("t6_rst",       {5'd0, a_reset}, 8'h07);
      chk("t6_rst_busy",  {7'd0, a_busy},  8'h01);
      chk("t6_rst_cause", {5'd0, a_cause}, 8'h01);
      chk("t6_b_rst",     {7'd0, b_reset}, 8'h01);
      chk("t6_b_cause",   {5'd0, b_cause}, 8'h01);
      reset_n = 1'b1;
      tick(1);
      chk("t6_b_rel",     {7'd0, b_reset}, 8'h00);
      chk("t6_a_hold",    {5'd0, a_reset}, 8'h07);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
